// File: rtl/led_shifter_pkg.sv
// rtl/led_shifter_pkg.sv - shared types, constants and frame packing for the LED serial output stage
// Contents: FRAME_BITS, FSM state type, pack_frame() which defines the on-wire bit order.
package ledshift_pkg;

  localparam int FRAME_BITS = 46;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  // MSB goes out first, so ledr[9] is the first bit on the wire and hex0[0] the last.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [6:0] hex0,
    input logic [6:0] hex1,
    input logic [6:0] hex2,
    input logic [6:0] hex3,
    input logic [7:0] ledg,
    input logic [9:0] ledr
  );
    return {ledr, ledg, hex3, hex2, hex1, hex0};
  endfunction

endpackage

// File: rtl/led_shifter_if.sv
// rtl/led_shifter_if.sv - serial link to the external 74HC595-style shift-register chain
// Signals: sclk (rising-edge sampled clock), sdata (MSB-first data), latch (storage strobe),
//          busy (frame in progress). master drives the link, slave observes it.
interface led_shifter_if;

  logic sclk;
  logic sdata;
  logic latch;
  logic busy;

  modport master (output sclk, sdata, latch, busy);
  modport slave  (input  sclk, sdata, latch, busy);

endinterface

// File: rtl/led_shift_tick.sv
// rtl/led_shift_tick.sv - CLK_DIV prescaler giving a one-cycle pulse at the end of each sclk phase
// Ports: clk, reset (async, active-high), clear (restart count), enable (count while set),
//        tick (high in the last cycle of each CLK_DIV-cycle phase).
module led_shift_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  // With CLK_DIV=1 LAST is 0, so tick is high on every enabled cycle.
  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/led_shifter.sv
// rtl/led_shifter.sv - shifts display/LED state into an external shift-register chain
// Ports: clk, reset (async, active-high); hex0..hex3 (7b active-low segments), ledg (8b),
//        ledr (10b) inputs; link (master): sclk, sdata, latch, busy.
// A 46-bit frame is sent after reset, on any input change and on periodic refresh.
module led_shifter
  import ledshift_pkg::*;
#(
  parameter int          CLK_DIV = 4,
  parameter int unsigned REFRESH = 2**20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [7:0] ledg,
  input  logic [9:0] ledr,
  led_shifter_if.master link
);

  state_t                  state;
  logic                    pending;
  logic [FRAME_BITS-1:0]   snapshot;
  logic [FRAME_BITS-1:0]   shreg;
  logic [5:0]              bit_cnt;
  logic [31:0]             refresh_cnt;
  logic                    high_phase;
  logic                    tick;

  logic [FRAME_BITS-1:0]   frame;
  logic                    refresh_expired;
  logic                    start_frame;

  assign frame = pack_frame(hex0, hex1, hex2, hex3, ledg, ledr);

  // REFRESH - 1 wraps when REFRESH is 0; the first term masks that case.
  assign refresh_expired = (REFRESH != 0) && (refresh_cnt == REFRESH - 1);

  // Change, refresh and pending all merge into one request, so coincident
  // causes only ever produce a single frame.
  assign start_frame = (state == IDLE) &&
                       (pending || (frame != snapshot) || refresh_expired);

  led_shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LOAD),
    .enable ((state == SHIFT) || (state == LATCH)),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b1;
      snapshot    <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      refresh_cnt <= '0;
      high_phase  <= 1'b0;
      link.sclk   <= 1'b0;
      link.sdata  <= 1'b0;
      link.latch  <= 1'b0;
      link.busy   <= 1'b0;
    end else begin
      // Cleared on the edge into LOAD so frame starts are exactly REFRESH cycles apart.
      if (start_frame) begin
        refresh_cnt <= '0;
      end else if ((REFRESH != 0) && (refresh_cnt != REFRESH)) begin
        refresh_cnt <= refresh_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          // Capture the same inputs that were compared, so a frame always
          // carries exactly the data that triggered it.
          if (start_frame) begin
            state     <= LOAD;
            shreg     <= frame;
            snapshot  <= frame;
            bit_cnt   <= 6'(FRAME_BITS - 1);
            pending   <= 1'b0;
            link.busy <= 1'b1;
          end
        end
        LOAD: begin
          state      <= SHIFT;
          high_phase <= 1'b0;
          link.sclk  <= 1'b0;
          link.sdata <= shreg[FRAME_BITS-1];
        end
        SHIFT: begin
          if (tick) begin
            if (!high_phase) begin
              high_phase <= 1'b1;
              link.sclk  <= 1'b1;
            end else begin
              high_phase <= 1'b0;
              link.sclk  <= 1'b0;
              shreg      <= {shreg[FRAME_BITS-2:0], 1'b0};
              if (bit_cnt == '0) begin
                state      <= LATCH;
                link.latch <= 1'b1;
              end else begin
                bit_cnt    <= bit_cnt - 6'd1;
                // New bit appears together with the falling sclk, i.e. at low-phase start.
                link.sdata <= shreg[FRAME_BITS-2];
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            state      <= IDLE;
            link.latch <= 1'b0;
            link.busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_shifter.sv
// tb/tb_led_shifter.sv - scoreboard bench for led_shifter (CLK_DIV 4/no refresh, 4/1000, 1/no refresh)
module tb_led_shifter;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [7:0] ledg;
  logic [9:0] ledr;

  always #5 clk = ~clk;

  led_shifter_if if0 ();
  led_shifter_if if1 ();
  led_shifter_if if2 ();

  led_shifter #(.CLK_DIV(4), .REFRESH(0)) dut0 (
    .clk(clk), .reset(rst[0]), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .ledg(ledg), .ledr(ledr), .link(if0)
  );
  led_shifter #(.CLK_DIV(4), .REFRESH(1000)) dut1 (
    .clk(clk), .reset(rst[1]), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .ledg(ledg), .ledr(ledr), .link(if1)
  );
  led_shifter #(.CLK_DIV(1), .REFRESH(0)) dut2 (
    .clk(clk), .reset(rst[2]), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .ledg(ledg), .ledr(ledr), .link(if2)
  );

  logic [2:0] sclk_w, sdata_w, latch_w, busy_w;
  assign sclk_w  = {if2.sclk,  if1.sclk,  if0.sclk};
  assign sdata_w = {if2.sdata, if1.sdata, if0.sdata};
  assign latch_w = {if2.latch, if1.latch, if0.latch};
  assign busy_w  = {if2.busy,  if1.busy,  if0.busy};

  logic [45:0] exp_q[$];
  logic [45:0] exp_f;
  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;
  int cyc = 0;

  logic [45:0] cap[3];
  int nbits[3], busy_cnt[3], latch_cnt[3];
  logic [2:0] p_sclk, p_sdata, p_latch, p_busy;
  int last_start = 0;
  bit have_start = 1'b0;
  int busy_len[3]  = '{373, 373, 94};
  int latch_len[3] = '{4, 4, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples every DUT on the falling clock edge, reassembles frames
  // from sclk rising edges and checks them against the queue at each latch.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        cap[i] = '0; nbits[i] = 0; busy_cnt[i] = 0; latch_cnt[i] = 0;
        p_sclk[i] = 1'b0; p_sdata[i] = 1'b0; p_latch[i] = 1'b0; p_busy[i] = 1'b0;
        if (i == 1) have_start = 1'b0;
      end else begin
        if (i == 1 && busy_w[i] && !p_busy[i]) begin
          if (have_start) check("refresh_period", 64'(cyc - last_start), 64'd1000);
          last_start = cyc;
          have_start = 1'b1;
        end
        if (busy_w[i]) busy_cnt[i]++;
        if (!busy_w[i] && p_busy[i]) begin
          check($sformatf("busy_len%0d", i), 64'(busy_cnt[i]), 64'(busy_len[i]));
          busy_cnt[i] = 0;
        end
        if (sclk_w[i] && !p_sclk[i]) begin
          cap[i] = {cap[i][44:0], sdata_w[i]};
          nbits[i]++;
        end
        if (!sclk_w[i] && p_sclk[i]) check($sformatf("sdata_hold%0d", i), 64'(p_sdata[i]), 64'(cap[i][0]));
        if (latch_w[i]) latch_cnt[i]++;
        if (latch_w[i] && !p_latch[i]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame%0d: got 0x%0h, expected no frame", i, cap[i]);
          end else begin
            exp_f = exp_q.pop_front();
            check($sformatf("frame_bits%0d", i), 64'(nbits[i]), 64'd46);
            check($sformatf("frame_data%0d", i), 64'(cap[i]), 64'(exp_f));
          end
          frames_done++;
          nbits[i] = 0;
        end
        if (!latch_w[i] && p_latch[i]) begin
          check($sformatf("latch_len%0d", i), 64'(latch_cnt[i]), 64'(latch_len[i]));
          latch_cnt[i] = 0;
        end
        p_sclk[i] = sclk_w[i]; p_sdata[i] = sdata_w[i];
        p_latch[i] = latch_w[i]; p_busy[i] = busy_w[i];
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_frames: got %0d frames, expected %0d within %0d cycles", frames_done, target, budget);
    end
  endtask

  task automatic wait_busy_low(input int budget);
    int n = 0;
    while (if0.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (if0.busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_busy_low: busy still %0b after %0d cycles", if0.busy, budget);
    end
  endtask

  initial begin
    rst = 3'b111;
    hex0 = '0; hex1 = '0; hex2 = '0; hex3 = '0; ledg = '0; ledr = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk",  64'(if0.sclk),  64'd0);
    check("rst_sdata", 64'(if0.sdata), 64'd0);
    check("rst_latch", 64'(if0.latch), 64'd0);
    check("rst_busy",  64'(if0.busy),  64'd0);

    // Frame after reset: all zeros.
    exp_q.push_back(46'h0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("first_load_busy", 64'(if0.busy), 64'd1);
    wait_frames(1, 500);
    repeat (5) @(negedge clk);

    // ledr all on, hex0 = 0x40.
    ledr = 10'h3FF; hex0 = 7'h40;
    exp_q.push_back(46'h3FF000000040);
    @(negedge clk);
    check("change_latency", 64'(if0.busy), 64'd1);
    wait_frames(2, 500);
    repeat (5) @(negedge clk);

    // Change mid-SHIFT: current frame keeps old data, next one follows after one IDLE cycle.
    hex1 = 7'h12;
    exp_q.push_back(46'h3FF000000940);
    repeat (100) @(negedge clk);
    ledg = 8'hA5;
    exp_q.push_back(46'h3FFA50000940);
    wait_busy_low(500);
    @(negedge clk);
    check("idle_gap", 64'(if0.busy), 64'd1);
    wait_frames(4, 900);
    repeat (5) @(negedge clk);

    // Reset during bit 20, then a full frame with current inputs.
    hex2 = 7'h55;
    repeat (165) @(negedge clk);
    check("busy_before_rst", 64'(if0.busy), 64'd1);
    rst[0] = 1'b1;
    #1;
    check("midrst_sclk",  64'(if0.sclk),  64'd0);
    check("midrst_sdata", 64'(if0.sdata), 64'd0);
    check("midrst_latch", 64'(if0.latch), 64'd0);
    check("midrst_busy",  64'(if0.busy),  64'd0);
    @(negedge clk);
    exp_q.push_back(46'h3FFA50154940);
    rst[0] = 1'b0;
    wait_frames(5, 500);
    repeat (5) @(negedge clk);
    rst[0] = 1'b1;

    // Refresh instance: three identical frames 1000 cycles apart.
    repeat (3) exp_q.push_back(46'h3FFA50154940);
    rst[1] = 1'b0;
    wait_frames(8, 3000);
    repeat (10) @(negedge clk);
    rst[1] = 1'b1;

    // CLK_DIV = 1 instance.
    hex3 = 7'h7F; ledg = 8'h3C;
    exp_q.push_back(46'h3FF3CFF54940);
    @(negedge clk);
    rst[2] = 1'b0;
    wait_frames(9, 300);
    repeat (5) @(negedge clk);
    ledr = 10'h155;
    exp_q.push_back(46'h1553CFF54940);
    wait_frames(10, 300);
    repeat (5) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
